// File: rtl/mc_link_pkg.sv
// Shared link definitions for the credit transmitter and the downstream CDC buffer.
// The LINK_* constants size both ends of the link so they cannot drift apart.
package mc_link_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } tx_state_e;

   localparam int LINK_CREDITS = 16;
   localparam int LINK_WIDTH   = 32;

endpackage

// File: rtl/credit_tx_source_sync_fifo_stage.sv
// Single-clock staging FIFO with combinational head data.
// The extra pointer bit tells full from empty.
module sync_fifo_stage #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             re_clk,
   input  logic             re_reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge re_clk or negedge re_reset_n) begin
      if (!re_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge re_clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/credit_tx_source.sv
// Credit-based transmitter feeding the CDC credit buffer: stages producer words
// and sends them as one-cycle beats only while credits are held.
module credit_tx_source
   import mc_link_pkg::*;
#(
   parameter int CREDITS     = LINK_CREDITS,
   parameter int WIDTH       = LINK_WIDTH,
   parameter int STAGE_DEPTH = 4,
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = $clog2(CREDITS + 1)
) (
   input  logic             re_clk,
   input  logic             re_reset_n,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   output logic             up_ready,
   input  logic             re_credit_pulse,
   output logic             re_valid,
   output logic [WIDTH-1:0] re_data,
   output logic [CNT_W-1:0] credit_count,
   output logic             credit_err
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   tx_state_e        r_state, w_state_nxt;
   logic [HW-1:0]    r_hold_cnt;
   logic [CNT_W-1:0] r_credit;
   logic             r_err;
   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   logic             w_full, w_empty, w_push, w_send_en, w_ovf, w_hold_done;
   logic [WIDTH-1:0] w_head;

   assign w_hold_done = (r_hold_cnt == HW'(HOLD_CYCLES - 1));
   assign up_ready    = (r_state == RUN) && !w_full;
   assign w_push      = up_valid && up_ready;
   assign w_send_en   = (r_state == RUN) && !w_empty && (r_credit != '0);
   // A returned credit with nothing leaving and a full count means the far side lost track.
   assign w_ovf       = re_credit_pulse && !w_send_en && (r_credit == CNT_W'(CREDITS));

   sync_fifo_stage #(
      .DEPTH (STAGE_DEPTH),
      .WIDTH (WIDTH)
   ) u_stage (
      .re_clk     (re_clk),
      .re_reset_n (re_reset_n),
      .i_push     (w_push),
      .i_data     (up_data),
      .i_pop      (w_send_en),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_head     (w_head)
   );

   always_ff @(posedge re_clk or negedge re_reset_n) begin
      if (!re_reset_n) r_state <= HOLD;
      else             r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         HOLD:    if (w_hold_done) w_state_nxt = RUN;
         RUN:     w_state_nxt = RUN;
         ERR:     w_state_nxt = ERR;
         default: w_state_nxt = HOLD;
      endcase
      if (w_ovf) w_state_nxt = ERR;
   end

   always_ff @(posedge re_clk or negedge re_reset_n) begin
      if (!re_reset_n) begin
         r_hold_cnt <= '0;
      end else if (r_state == HOLD && !w_hold_done) begin
         r_hold_cnt <= r_hold_cnt + 1'b1;
      end
   end

   // Credits keep counting during HOLD so returns racing reset release are not lost.
   always_ff @(posedge re_clk or negedge re_reset_n) begin
      if (!re_reset_n) begin
         r_credit <= CNT_W'(CREDITS);
         r_err    <= 1'b0;
      end else begin
         case ({w_send_en, re_credit_pulse})
            2'b10:   r_credit <= r_credit - CNT_W'(1);
            2'b01:   if (r_credit != CNT_W'(CREDITS)) r_credit <= r_credit + CNT_W'(1);
            default: r_credit <= r_credit;
         endcase
         if (w_ovf) r_err <= 1'b1;
      end
   end

   always_ff @(posedge re_clk or negedge re_reset_n) begin
      if (!re_reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= w_send_en;
         if (w_send_en) r_data <= w_head;
      end
   end

   assign re_valid     = r_valid;
   assign re_data      = r_data;
   assign credit_count = r_credit;
   assign credit_err   = r_err;

endmodule

// File: tb/tb_credit_tx_source.sv
// Directed bench for credit_tx_source: hold window, ordering, starvation,
// credit return, simultaneous send/return, overflow and mid-stream reset.
module tb_credit_tx_source;

   localparam int W  = 32;
   localparam int CW = 5;

   logic          re_clk = 1'b0;
   logic          re_reset_n = 1'b0;
   logic          up_valid = 1'b0;
   logic [W-1:0]  up_data = '0;
   logic          up_ready;
   logic          re_credit_pulse = 1'b0;
   logic          re_valid;
   logic [W-1:0]  re_data;
   logic [CW-1:0] credit_count;
   logic          credit_err;

   int vec  = 0;
   int errs = 0;
   int cyc_n = 0;
   logic [W-1:0] rx_q[$];
   int           rx_t[$];

   credit_tx_source dut (
      .re_clk          (re_clk),
      .re_reset_n      (re_reset_n),
      .up_valid        (up_valid),
      .up_data         (up_data),
      .up_ready        (up_ready),
      .re_credit_pulse (re_credit_pulse),
      .re_valid        (re_valid),
      .re_data         (re_data),
      .credit_count    (credit_count),
      .credit_err      (credit_err)
   );

   always #5 re_clk = ~re_clk;

   always @(posedge re_clk) cyc_n = cyc_n + 1;

   // Each beat is high for a whole cycle, so one falling edge sees it exactly once.
   always @(negedge re_clk) begin
      if (re_valid) begin
         rx_q.push_back(re_data);
         rx_t.push_back(cyc_n);
      end
   end

   task automatic cyc();
      @(posedge re_clk);
      #1;
   endtask

   task automatic reset_dut();
      re_reset_n = 1'b0;
      up_valid = 1'b0;
      re_credit_pulse = 1'b0;
      repeat (3) cyc();
      re_reset_n = 1'b1;
   endtask

   task automatic send_words(input logic [W-1:0] base, input int n, input int budget);
      int acc = 0;
      int k = 0;
      while (acc < n && k < budget) begin
         up_valid = 1'b1;
         up_data  = base + W'(acc);
         if (up_ready) acc++;
         cyc();
         k++;
      end
      up_valid = 1'b0;
      if (acc < n) begin
         vec++; errs++;
         $display("FAIL send_words accepted %0d words, required %0d", acc, n);
      end
   endtask

   task automatic test_reset();
      reset_dut();
      re_reset_n = 1'b0;
      #1;
      vec++; if (re_valid !== 1'b0)        begin errs++; $display("FAIL rst_valid got %b exp 0", re_valid); end
      vec++; if (up_ready !== 1'b0)        begin errs++; $display("FAIL rst_ready got %b exp 0", up_ready); end
      vec++; if (re_data !== '0)           begin errs++; $display("FAIL rst_data got %h exp 0", re_data); end
      vec++; if (credit_count !== 5'd16)   begin errs++; $display("FAIL rst_credit got %0d exp 16", credit_count); end
      vec++; if (credit_err !== 1'b0)      begin errs++; $display("FAIL rst_err got %b exp 0", credit_err); end
      re_reset_n = 1'b1;
   endtask

   task automatic test_hold_and_starve();
      rx_q.delete(); rx_t.delete();
      for (int i = 0; i < 4; i++) begin
         up_valid = 1'b1; up_data = 32'h1;
         vec++; if (up_ready !== 1'b0) begin errs++; $display("FAIL hold_ready cycle %0d got %b exp 0", i, up_ready); end
         cyc();
      end
      vec++; if (up_ready !== 1'b1) begin errs++; $display("FAIL run_ready got %b exp 1", up_ready); end
      send_words(32'h1, 20, 60);
      repeat (10) cyc();
      vec++; if (rx_q.size() != 16) begin errs++; $display("FAIL starve_beats got %0d exp 16", rx_q.size()); end
      for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
         vec++; if (rx_q[i] !== W'(i + 1)) begin errs++; $display("FAIL order beat %0d got %h exp %h", i, rx_q[i], i + 1); end
      end
      if (rx_t.size() == 16) begin
         vec++; if (rx_t[15] - rx_t[0] != 15) begin errs++; $display("FAIL back_to_back span got %0d exp 15", rx_t[15] - rx_t[0]); end
      end
      vec++; if (credit_count !== 5'd0) begin errs++; $display("FAIL starve_credit got %0d exp 0", credit_count); end
      vec++; if (up_ready !== 1'b0)     begin errs++; $display("FAIL starve_full_ready got %b exp 0", up_ready); end
      vec++; if (re_valid !== 1'b0)     begin errs++; $display("FAIL starve_valid got %b exp 0", re_valid); end
      vec++; if (re_data !== 32'h10)    begin errs++; $display("FAIL data_hold got %h exp 10", re_data); end
   endtask

   task automatic test_credit_return();
      rx_q.delete(); rx_t.delete();
      for (int i = 0; i < 3; i++) begin
         re_credit_pulse = 1'b1;
         cyc();
      end
      re_credit_pulse = 1'b0;
      repeat (5) cyc();
      vec++; if (rx_q.size() != 3) begin errs++; $display("FAIL ret_beats got %0d exp 3", rx_q.size()); end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         vec++; if (rx_q[i] !== W'(32'h11 + i)) begin errs++; $display("FAIL ret_word %0d got %h exp %h", i, rx_q[i], 32'h11 + i); end
      end
      vec++; if (credit_count !== 5'd0) begin errs++; $display("FAIL ret_credit got %0d exp 0", credit_count); end
      vec++; if (up_ready !== 1'b1)     begin errs++; $display("FAIL ret_ready got %b exp 1", up_ready); end
   endtask

   task automatic test_simultaneous();
      reset_dut();
      repeat (4) cyc();
      send_words(32'h100, 11, 40);
      repeat (5) cyc();
      vec++; if (credit_count !== 5'd5) begin errs++; $display("FAIL sim_pre_credit got %0d exp 5", credit_count); end
      up_valid = 1'b1; up_data = 32'hA5;
      cyc();
      up_valid = 1'b0; re_credit_pulse = 1'b1;
      cyc();
      re_credit_pulse = 1'b0;
      vec++; if (credit_count !== 5'd5) begin errs++; $display("FAIL sim_credit got %0d exp 5", credit_count); end
      vec++; if (re_valid !== 1'b1)     begin errs++; $display("FAIL sim_valid got %b exp 1", re_valid); end
      vec++; if (re_data !== 32'hA5)    begin errs++; $display("FAIL sim_data got %h exp a5", re_data); end
      cyc();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 11; i++) begin
         re_credit_pulse = 1'b1;
         cyc();
      end
      re_credit_pulse = 1'b0;
      vec++; if (credit_count !== 5'd16) begin errs++; $display("FAIL ovf_pre_credit got %0d exp 16", credit_count); end
      vec++; if (credit_err !== 1'b0)    begin errs++; $display("FAIL ovf_pre_err got %b exp 0", credit_err); end
      re_credit_pulse = 1'b1;
      cyc();
      re_credit_pulse = 1'b0;
      vec++; if (credit_err !== 1'b1)    begin errs++; $display("FAIL ovf_err got %b exp 1", credit_err); end
      vec++; if (credit_count !== 5'd16) begin errs++; $display("FAIL ovf_credit got %0d exp 16", credit_count); end
      rx_q.delete(); rx_t.delete();
      up_valid = 1'b1; up_data = 32'hBAD;
      repeat (5) cyc();
      vec++; if (up_ready !== 1'b0)  begin errs++; $display("FAIL ovf_ready got %b exp 0", up_ready); end
      up_valid = 1'b0;
      re_credit_pulse = 1'b1;
      cyc();
      re_credit_pulse = 1'b0;
      repeat (2) cyc();
      vec++; if (rx_q.size() != 0)   begin errs++; $display("FAIL ovf_beats got %0d exp 0", rx_q.size()); end
      vec++; if (credit_count !== 5'd16) begin errs++; $display("FAIL ovf_sat got %0d exp 16", credit_count); end
      vec++; if (credit_err !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b exp 1", credit_err); end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      vec++; if (credit_err !== 1'b0) begin errs++; $display("FAIL err_clear got %b exp 0", credit_err); end
      repeat (4) cyc();
      send_words(32'h200, 7, 40);
      repeat (4) cyc();
      vec++; if (credit_count !== 5'd9) begin errs++; $display("FAIL mid_pre_credit got %0d exp 9", credit_count); end
      up_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         up_data = W'(32'h300 + i);
         cyc();
      end
      #2 re_reset_n = 1'b0;
      up_valid = 1'b0;
      #1;
      vec++; if (re_valid !== 1'b0)      begin errs++; $display("FAIL mid_valid got %b exp 0", re_valid); end
      vec++; if (up_ready !== 1'b0)      begin errs++; $display("FAIL mid_ready got %b exp 0", up_ready); end
      vec++; if (credit_err !== 1'b0)    begin errs++; $display("FAIL mid_err got %b exp 0", credit_err); end
      vec++; if (credit_count !== 5'd16) begin errs++; $display("FAIL mid_credit got %0d exp 16", credit_count); end
      rx_q.delete(); rx_t.delete();
      cyc();
      re_reset_n = 1'b1;
      repeat (12) cyc();
      vec++; if (rx_q.size() != 0)       begin errs++; $display("FAIL mid_stale got %0d beats exp 0", rx_q.size()); end
      vec++; if (credit_count !== 5'd16) begin errs++; $display("FAIL mid_post_credit got %0d exp 16", credit_count); end
   endtask

   initial begin
      test_reset();
      test_hold_and_starve();
      test_credit_return();
      test_simultaneous();
      test_overflow();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout bench did not complete");
      $fatal(1);
   end

endmodule
